key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_sync.sv | 34 +++
 rtl/key_debounce.sv | 136 +++++++++++++
 tb/tb_key_debounce.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debouncer.
// State encodings and counter widths sized to the parameter maxima.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int DCNT_W = 20;
  localparam int HCNT_W = 26;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous level input.
// Both stages reset to RST_VAL so the output starts in a known level.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  // Next values of the two synchronizer stages
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Synchronizer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low push-button into level, strobes and a
// wrapping press counter; long-hold detection once per press.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key,
  output logic             pressed,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [WIDTH-1:0] press_count
);

  localparam logic [DCNT_W-1:0] D_LAST =
    DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] H_LAST =
    HCNT_W'(LONG_CYCLES - 1);

  logic key_s;

  state_e            state_d, state_q;
  logic [DCNT_W-1:0] dcnt_d, dcnt_q;
  logic [HCNT_W-1:0] hcnt_d, hcnt_q;
  logic              long_done_d, long_done_q;
  logic              pressed_d, pressed_q;
  logic              press_pulse_d, press_pulse_q;
  logic              release_pulse_d, release_pulse_q;
  logic              long_pulse_d, long_pulse_q;
  logic [WIDTH-1:0]  press_count_d, press_count_q;

  key_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key),
    .q   (key_s)
  );

  // Next-state, counters and registered-output values
  always_comb begin
    state_d         = state_q;
    dcnt_d          = dcnt_q;
    hcnt_d          = hcnt_q;
    long_done_d     = long_done_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    press_count_d   = press_count_q;
    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d       = PRESSED;
          press_pulse_d = 1'b1;
          hcnt_d        = '0;
          long_done_d   = 1'b0;
          press_count_d = press_count_q + WIDTH'(1);
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end else if (hcnt_q == H_LAST) begin
          if (!long_done_q) begin
            long_pulse_d = 1'b1;
            long_done_d  = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (dcnt_q == D_LAST) begin
          state_d         = IDLE;
          release_pulse_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pressed_d = (state_d == PRESSED) ||
                (state_d == RELEASE_WAIT);
  end

  // State, counters and outputs; reset wins over any pending event
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      dcnt_q          <= '0;
      hcnt_q          <= '0;
      long_done_q     <= 1'b0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      press_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      dcnt_q          <= dcnt_d;
      hcnt_q          <= hcnt_d;
      long_done_q     <= long_done_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      press_count_q   <= press_count_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_count   = press_count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a strobe scoreboard.
// Expected strobes are queued with their cycle when key is driven.
module tb_key_debounce;

  localparam int W  = 8;
  localparam int DC = 4;
  localparam int LC = 16;
  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;
  localparam int K_LONG  = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key = 1'b1;
  logic         pressed;
  logic         press_pulse;
  logic         release_pulse;
  logic         long_pulse;
  logic [W-1:0] press_count;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  int  exp_cnt = 0;
  ev_t sbq[$];

  key_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .LONG_CYCLES     (LC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic mon(input logic s, input int k);
    ev_t e;
    if (s) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $error("FAIL strobe kind=%0d at cyc=%0d, expected none",
               k, cyc);
      end else begin
        e = sbq.pop_front();
        assert (e.kind === k && e.cyc === cyc) else begin
          errors++;
          $error("FAIL strobe observed kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                 k, cyc, e.kind, e.cyc);
        end
      end
    end
  endtask

  // Scoreboard: compare strobes and flag overdue expectations
  always @(negedge clk) begin
    mon(press_pulse, K_PRESS);
    mon(release_pulse, K_REL);
    mon(long_pulse, K_LONG);
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      checks++;
      errors++;
      $error("FAIL missing strobe kind=%0d expected cyc=%0d now=%0d",
             sbq[0].kind, sbq[0].cyc, cyc);
      void'(sbq.pop_front());
    end
  end

  initial begin
    step(3);
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_count", 32'(press_count), 0);
    chk("rst_strobes",
        32'({press_pulse, release_pulse, long_pulse}), 0);
    rst = 1'b0;
    step(2);

    key = 1'b0;
    push(K_PRESS, cyc + 7);
    exp_cnt++;
    step(10);
    chk("clean_pressed", 32'(pressed), 1);
    chk("clean_count", 32'(press_count), 32'(exp_cnt % 256));
    key = 1'b1;
    push(K_REL, cyc + 7);
    step(12);
    chk("clean_released", 32'(pressed), 0);

    repeat (5) begin
      key = 1'b0;
      step(3);
      key = 1'b1;
      step(4);
    end
    step(6);
    chk("bounce_pressed", 32'(pressed), 0);
    chk("bounce_count", 32'(press_count), 32'(exp_cnt % 256));

    key = 1'b0;
    push(K_PRESS, cyc + 7);
    push(K_LONG, cyc + 7 + LC);
    exp_cnt++;
    step(30);
    chk("long_pressed", 32'(pressed), 1);
    key = 1'b1;
    push(K_REL, cyc + 7);
    step(12);
    chk("long_count", 32'(press_count), 32'(exp_cnt % 256));

    key = 1'b0;
    push(K_PRESS, cyc + 7);
    exp_cnt++;
    step(10);
    key = 1'b1;
    step(2);
    key = 1'b0;
    step(2);
    chk("glitch_pressed_a", 32'(pressed), 1);
    step(1);
    chk("glitch_pressed_b", 32'(pressed), 1);
    chk("glitch_count", 32'(press_count), 32'(exp_cnt % 256));
    key = 1'b1;
    push(K_REL, cyc + 7);
    step(12);

    key = 1'b0;
    push(K_PRESS, cyc + 7);
    step(9);
    chk("rstmid_pressed", 32'(pressed), 1);
    rst = 1'b1;
    step(1);
    chk("rstmid_outs",
        32'({pressed, press_pulse, release_pulse, long_pulse}), 0);
    chk("rstmid_count", 32'(press_count), 0);
    rst = 1'b0;
    push(K_PRESS, cyc + 7);
    exp_cnt = 1;
    step(10);
    chk("rstmid_repress", 32'(pressed), 1);
    chk("rstmid_count2", 32'(press_count), 1);
    key = 1'b1;
    push(K_REL, cyc + 7);
    step(12);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_cnt = 0;
    step(2);
    repeat (257) begin
      key = 1'b0;
      push(K_PRESS, cyc + 7);
      exp_cnt++;
      step(8);
      key = 1'b1;
      push(K_REL, cyc + 7);
      step(8);
    end
    step(10);
    chk("wrap_count", 32'(press_count), 32'(exp_cnt % 256));
    chk("wrap_pressed", 32'(pressed), 0);

    step(5);
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
